// File: rtl/bb_pkg.sv
// Shared constants and types for the bit-blade dot-product sequencer.
//   N_LANES  operand pairs per vector
//   OP_W     operand width, sliced into NB blades of BLADE_W bits
//   PE_OUT_W width of the PE array sum (two's complement)
//   PE_LAT   PE register latency from issue to pe_out
//   ACC_W    signed width of the accumulated dot product
package bb_pkg;

  localparam int N_LANES  = 16;
  localparam int OP_W     = 8;
  localparam int BLADE_W  = 2;
  localparam int NB       = OP_W / BLADE_W;
  localparam int BIDX_W   = $clog2(NB);
  localparam int CNT_W    = 2 * BIDX_W;
  localparam int PE_OUT_W = 10;
  localparam int PE_LAT   = 1;
  localparam int ACC_W    = 2 * OP_W + $clog2(N_LANES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Left-shift applied to a PE sum: blade weights 2^(2i) * 2^(2j).
  typedef logic [3:0] tag_t;

  function automatic tag_t shift_tag(input logic [BIDX_W-1:0] i, input logic [BIDX_W-1:0] j);
    return tag_t'(BLADE_W * (int'(i) + int'(j)));
  endfunction

endpackage

// File: rtl/bb_blade_seq_dotp8_if.sv
// Bundle of the sequencer's operand stream, result stream and PE-array bus.
//   s_*    operand vector handshake (valid/ready) with x/w lanes and signedness
//   pe_*   blade operands and sign flags toward the PE array, pe_out back
//   m_*    dot-product result handshake (valid/ready)
// Modport master is the sequencer side; slave is the surrounding environment.
interface bb_blade_seq_dotp8_if;
  import bb_pkg::*;

  logic                          s_valid;
  logic                          s_ready;
  logic [N_LANES*OP_W-1:0]       s_x;
  logic [N_LANES*OP_W-1:0]       s_w;
  logic                          s_x_signed;
  logic                          s_w_signed;

  logic [N_LANES*BLADE_W-1:0]    pe_in1;
  logic [N_LANES-1:0]            pe_sn1;
  logic [N_LANES*BLADE_W-1:0]    pe_in2;
  logic [N_LANES-1:0]            pe_sn2;
  logic signed [PE_OUT_W-1:0]    pe_out;

  logic                          m_valid;
  logic                          m_ready;
  logic signed [ACC_W-1:0]       m_data;

  modport master (
    input  s_valid, s_x, s_w, s_x_signed, s_w_signed, pe_out, m_ready,
    output s_ready, pe_in1, pe_sn1, pe_in2, pe_sn2, m_valid, m_data
  );

  modport slave (
    output s_valid, s_x, s_w, s_x_signed, s_w_signed, pe_out, m_ready,
    input  s_ready, pe_in1, pe_sn1, pe_in2, pe_sn2, m_valid, m_data
  );

endinterface

// File: rtl/bb_blade_slice.sv
// Combinational blade selector for one operand side.
//   ops        N_LANES packed operands, lane k at [OP_W*k +: OP_W]
//   idx        blade index (0 = least significant blade)
//   is_signed  operands are two's complement
//   blades     selected blade of every lane, lane k at [BLADE_W*k +: BLADE_W]
//   sn         per-lane sign flag: only the MSB blade of a signed operand is negative-weighted
module bb_blade_slice
  import bb_pkg::*;
(
  input  logic [N_LANES*OP_W-1:0]    ops,
  input  logic [BIDX_W-1:0]          idx,
  input  logic                       is_signed,
  output logic [N_LANES*BLADE_W-1:0] blades,
  output logic [N_LANES-1:0]         sn
);

  logic msb_blade;

  assign msb_blade = (idx == BIDX_W'(NB - 1));

  always_comb begin
    blades = '0;
    sn     = '0;
    for (int k = 0; k < N_LANES; k++) begin
      blades[k*BLADE_W +: BLADE_W] = ops[k*OP_W + int'(idx)*BLADE_W +: BLADE_W];
      sn[k]                        = is_signed & msb_blade;
    end
  end

endmodule

// File: rtl/bb_blade_seq_dotp8.sv
// Bit-blade dot-product sequencer.
// Accepts one vector pair (x, w) of N_LANES operands, sweeps all NB*NB blade
// pairs (i, j) through the external PE array and shift-accumulates each PE sum
// by 2*(i+j) into a signed ACC_W-bit dot product.
//   clk, rst   clock and asynchronous active-high reset
//   bus        operand stream in, PE bus out/in, result stream out (master side)
//   busy       high whenever the sequencer is not idle
module bb_blade_seq_dotp8
  import bb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bb_blade_seq_dotp8_if.master bus,
  output logic                 busy
);

  state_e                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic                       accept;
  logic                       issue_p0;
  logic                       cnt_last;
  logic                       drain_last;
  logic                       result_hs;

  logic [N_LANES*OP_W-1:0]    x_hold, w_hold;
  logic                       x_signed, w_signed;

  logic [BIDX_W-1:0]          i_idx, j_idx;
  logic [N_LANES*BLADE_W-1:0] x_blades, w_blades;
  logic [N_LANES-1:0]         x_sn, w_sn;

  tag_t                       tag_p0;
  tag_t                       tag_pipe [PE_LAT];
  logic [PE_LAT-1:0]          vld_pipe;

  logic signed [ACC_W-1:0]    acc, acc_nxt;

  // Sign-extend a PE sum to the accumulator width and apply its blade weight.
  function automatic logic signed [ACC_W-1:0] scale_pe(
    input logic signed [PE_OUT_W-1:0] v,
    input tag_t                       sh
  );
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-PE_OUT_W){v[PE_OUT_W-1]}}, v};
    return ext <<< sh;
  endfunction

  // x blade index is the upper half of cnt, w blade index the lower half,
  // so each x blade is held while all w blades go past.
  assign i_idx      = cnt[CNT_W-1 -: BIDX_W];
  assign j_idx      = cnt[BIDX_W-1:0];
  assign cnt_last   = (cnt == '1);
  assign drain_last = (cnt == CNT_W'(PE_LAT - 1));
  assign accept     = (state == IDLE) && bus.s_valid;
  assign result_hs  = bus.m_valid && bus.m_ready;
  assign tag_p0     = shift_tag(i_idx, j_idx);

  bb_blade_slice u_x_slice (
    .ops       (x_hold),
    .idx       (i_idx),
    .is_signed (x_signed),
    .blades    (x_blades),
    .sn        (x_sn)
  );

  bb_blade_slice u_w_slice (
    .ops       (w_hold),
    .idx       (j_idx),
    .is_signed (w_signed),
    .blades    (w_blades),
    .sn        (w_sn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.s_valid) state_nxt = ISSUE;
      ISSUE:   if (cnt_last)    state_nxt = DRAIN;
      DRAIN:   if (drain_last)  state_nxt = DONE;
      DONE:    if (bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Blade operands are forced to zero outside ISSUE so the PE array idles on zeros.
  always_comb begin
    issue_p0    = (state == ISSUE);
    bus.s_ready = (state == IDLE);
    busy        = (state != IDLE);
    bus.pe_in1  = issue_p0 ? x_blades : '0;
    bus.pe_sn1  = issue_p0 ? x_sn     : '0;
    bus.pe_in2  = issue_p0 ? w_blades : '0;
    bus.pe_sn2  = issue_p0 ? w_sn     : '0;
  end

  // ---- issue (p0) -> PE result (after PE_LAT) boundary ----
  assign acc_nxt = acc + (vld_pipe[PE_LAT-1] ? scale_pe(bus.pe_out, tag_pipe[PE_LAT-1])
                                             : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      vld_pipe    <= '0;
      acc         <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
    end else begin
      vld_pipe[0] <= issue_p0;
      for (int s = 1; s < PE_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
      end

      unique case (state)
        IDLE:    if (accept) cnt <= '0;
        ISSUE:   cnt <= cnt_last ? '0 : cnt + 1'b1;
        DRAIN:   cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase

      if (accept) begin
        acc <= '0;
      end else begin
        acc <= acc_nxt;
      end

      // The last delayed product lands in the final DRAIN cycle, so the
      // result register takes acc_nxt rather than acc.
      if ((state == DRAIN) && drain_last) begin
        bus.m_data  <= acc_nxt;
        bus.m_valid <= 1'b1;
      end else if (result_hs) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

  // Operand hold and shift-tag delay line carry data only; the valid bits
  // above decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_hold   <= bus.s_x;
      w_hold   <= bus.s_w;
      x_signed <= bus.s_x_signed;
      w_signed <= bus.s_w_signed;
    end
    tag_pipe[0] <= tag_p0;
    for (int s = 1; s < PE_LAT; s++) begin
      tag_pipe[s] <= tag_pipe[s-1];
    end
  end

endmodule
